// File: rtl/seg_scan_driver_if.sv
// Bundles the display request inputs and the multiplexed segment outputs of seg_scan_driver.
// The master drives value/load/control; the slave (the driver) returns seg/dp/an/frame_tick.
interface seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    lz_blank;
  logic                    blink_en;
  logic                    enable;
  logic [0:6]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output value, load, dp_mask, lz_blank, blink_en, enable,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  value, load, dp_mask, lz_blank, blink_en, enable,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous value capture,
// leading-zero blanking and frame-counted blinking. Outputs are registered (1-cycle latency).
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input logic              clk,
  input logic              reset,
  seg_scan_driver_if.slave bus
);
  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CntW-1:0]       ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [FrmW-1:0]       FrmLast  = FrmW'(BLINK_FRAMES - 1);
  localparam logic [0:6]            SegOff   = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AnOff    = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CntW-1:0]         scan_q;
  logic [IdxW-1:0]         idx_q;
  logic [FrmW-1:0]         frm_q;
  logic                    phase_q;
  logic                    pending_q;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dpm_q;
  logic [0:6]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    tick_q;

  logic step, wrap;
  assign step = (scan_q == ScanLast);
  assign wrap = step && (idx_q == IdxLast);

  // Shadow registers only change on the frame wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q    <= '0;
      idx_q     <= '0;
      frm_q     <= '0;
      phase_q   <= 1'b0;
      pending_q <= 1'b0;
      val_q     <= '0;
      dpm_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      scan_q <= step ? '0 : scan_q + 1'b1;
      if (step) idx_q <= wrap ? '0 : idx_q + 1'b1;
      tick_q <= wrap;
      if (wrap) begin
        frm_q <= (frm_q == FrmLast) ? '0 : frm_q + 1'b1;
        if (frm_q == FrmLast) phase_q <= ~phase_q;
        if (pending_q || bus.load) begin
          val_q <= bus.value;
          dpm_q <= bus.dp_mask;
        end
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
    end
  end

  function automatic logic [0:6] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  // nz_from[i] is set when any shadow nibble at position i or above is non-zero.
  logic [NUM_DIGITS-1:0] nz_from;
  logic                  nz_run;
  always_comb begin
    nz_run  = 1'b0;
    nz_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_run     = nz_run | (|val_q[4*i +: 4]);
      nz_from[i] = nz_run;
    end
  end

  logic [3:0] nib;
  assign nib = val_q[{idx_q, 2'b00} +: 4];

  logic                  show, blank, dp_on;
  logic [0:6]            seg_on;
  logic [NUM_DIGITS-1:0] an_on;
  always_comb begin
    show   = bus.enable && !(bus.blink_en && phase_q);
    blank  = bus.lz_blank && (idx_q != '0) && !nz_from[idx_q];
    an_on  = '0;
    if (show) an_on[idx_q] = 1'b1;
    seg_on = (show && !blank) ? ~glyph(nib) : '0;
    dp_on  = show && !blank && dpm_q[idx_q];
  end

  // Internal levels are active-high; XOR with the off pattern gives the pad polarity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SegOff;
      dp_q  <= ACTIVE_LOW;
      an_q  <= AnOff;
    end else begin
      seg_q <= SegOff ^ seg_on;
      dp_q  <= ACTIVE_LOW ^ dp_on;
      an_q  <= AnOff ^ an_on;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit is driven (>=2).
REQ-003 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>=1).
REQ-004 Parameter ACTIVE_LOW, default 1; 1 = seg/dp/an asserted low, 0 = asserted high.
REQ-005 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 rightmost.
REQ-008 Port load  in  1  single-cycle request to capture value and dp_mask.
REQ-009 Port dp_mask  in  NUM_DIGITS  decimal point per digit, captured with value.
REQ-010 Port lz_blank  in  1  leading-zero suppression enable, used live.
REQ-011 Port blink_en  in  1  blink enable, used live.
REQ-012 Port enable  in  1  0 = all outputs inactive; counters keep running.
REQ-013 Port seg  out  7 [0:6]  segments a..g, seg[0]=a, seg[6]=g, registered.
REQ-014 Port dp  out  1  decimal point of the digit currently driven, registered.
REQ-015 Port an  out  NUM_DIGITS  digit select, at most one active, registered.
REQ-016 Port frame_tick  out  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-017 scan_cnt SHALL count 0..SCAN_DIV-1, wrapping to 0; digit index idx SHALL advance when scan_cnt=SCAN_DIV-1.
REQ-018 idx SHALL count 0..NUM_DIGITS-1 and wrap to 0; frame_tick SHALL be 1 exactly on the cycle idx is updated from NUM_DIGITS-1 to 0.
REQ-019 load=1 SHALL set a pending flag; the shadow registers (value, dp_mask) SHALL update only at the frame boundary (idx wrap), then pending clears -- no tearing within a frame.
REQ-020 load coincident with the wrap cycle SHALL capture that cycle's value/dp_mask immediately; pending stays 0.
REQ-021 Repeated load before the boundary SHALL cause capture of the inputs present on the boundary cycle.
REQ-022 Glyphs (active-low a..g): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000; ACTIVE_LOW=0 inverts all.
REQ-023 Outputs SHALL be registered: seg/dp/an on cycle N+1 reflect idx and shadow state on cycle N (1-cycle latency).
REQ-024 an SHALL activate only bit idx; dp SHALL equal shadow dp_mask[idx].
REQ-025 With lz_blank=1, digit i>0 SHALL be blank (all segments and dp inactive, an still active) when shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 never suppressed.
REQ-026 blink phase SHALL toggle after every BLINK_FRAMES frame_ticks; blink_en=1 with phase=1 SHALL force an, seg, dp inactive; phase runs regardless of blink_en.
REQ-027 enable=0 SHALL force an, seg, dp inactive on the next cycle; frame_tick still pulses.

Reset
REQ-028 reset=1 SHALL immediately clear scan_cnt, idx, pending, blink phase, frame counter, shadow value and dp_mask to 0.
REQ-029 During reset an, seg, dp SHALL be inactive (ACTIVE_LOW=1: all ones) and frame_tick 0.
REQ-030 First rising edge after reset release SHALL drive digit 0 of glyph 0 (if enable=1).
REQ-031 Reset asserted mid-frame SHALL discard a pending load.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1)
REQ-032 Reset release, enable=1 -> cycle 1: an=1110, seg=0000001, dp=1; an rotates 1101,1011,0111 every 4 cycles; frame_tick at cycle 16.
REQ-033 load with value=16'h12AF, dp_mask=0010 mid-frame -> display unchanged until wrap; next frame digits show F, A (dp=0), 2, 1.
REQ-034 lz_blank=1, value=16'h0050 -> digits 3,2 seg=1111111 with an active; digit 1 seg=0100100; digit 0 seg=0000001; value=16'h0000 -> only digit 0 lit.
REQ-035 blink_en=1 -> an=1111 during frames 3-4, 7-8, ...; blink_en=0 -> no blanking.
REQ-036 load on the wrap cycle -> new value shown from digit 0 of the same new frame; reset mid-frame with pending load -> value stays 0.
